// File: rtl/mdu_pkg.sv
// Shared MDU definitions: op encodings, sequencer state and op classification helpers.
// Imported by the MDU and by the Stall unit.
package mdu_pkg;

    localparam logic [2:0] MDU_MULT  = 3'd0;
    localparam logic [2:0] MDU_MULTU = 3'd1;
    localparam logic [2:0] MDU_DIV   = 3'd2;
    localparam logic [2:0] MDU_DIVU  = 3'd3;
    localparam logic [2:0] MDU_MTHI  = 3'd4;
    localparam logic [2:0] MDU_MTLO  = 3'd5;

    typedef enum logic {IDLE, RUN} mdu_state_e;

    // Long ops occupy the sequencer; mthi/mtlo complete at the accepting edge.
    function automatic logic mdu_is_long(input logic [2:0] op);
        return op <= MDU_DIVU;
    endfunction

    function automatic logic mdu_is_valid(input logic [2:0] op);
        return op <= MDU_MTLO;
    endfunction

endpackage

// File: rtl/mdu_if.sv
// EX-stage to MDU bundle: instruction issue, forwarded operands, busy and HI/LO.
interface mdu_if;
    logic        start;
    logic [2:0]  op;
    logic        cancel;
    logic [31:0] rs;
    logic [31:0] rt;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (output start, op, cancel, rs, rt, input busy, hi, lo);
    modport slave  (input start, op, cancel, rs, rt, output busy, hi, lo);
endinterface

// File: rtl/mdu_arith.sv
// Combinational MDU datapath: signed/unsigned 32x32 multiply and divide.
// div0 flags a divide with a zero divisor so the sequencer can leave HI/LO untouched.
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        div0
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] sdiv;
    logic [31:0] udiv;
    logic [31:0] quot_s;
    logic [31:0] rem_s;
    logic [31:0] quot_u;
    logic [31:0] rem_u;
    logic        rt_zero;
    logic        ovf;

    assign rt_zero = (rt == 32'd0);
    assign ovf     = (rs == 32'h8000_0000) && (rt == 32'hFFFF_FFFF);

    assign prod_s = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
    assign prod_u = {32'd0, rs} * {32'd0, rt};

    // Substituting 1 for a zero divisor avoids X; for INT_MIN/-1 it also yields
    // exactly the wrapped result (quotient 0x80000000, remainder 0).
    assign sdiv = (rt_zero || ovf) ? 32'd1 : rt;
    assign udiv = rt_zero ? 32'd1 : rt;

    assign quot_s = $signed(rs) / $signed(sdiv);
    assign rem_s  = $signed(rs) % $signed(sdiv);
    assign quot_u = rs / udiv;
    assign rem_u  = rs % udiv;

    always_comb begin
        res_hi = 32'd0;
        res_lo = 32'd0;
        div0   = 1'b0;
        case (op)
            MDU_MULT:  {res_hi, res_lo} = prod_s;
            MDU_MULTU: {res_hi, res_lo} = prod_u;
            MDU_DIV: begin
                res_hi = rem_s;
                res_lo = quot_s;
                div0   = rt_zero;
            end
            MDU_DIVU: begin
                res_hi = rem_u;
                res_lo = quot_u;
                div0   = rt_zero;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide sequencer owning HI/LO. Results are captured at issue and
// committed after a fixed per-op latency, during which busy is held high.
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10,
    parameter int unsigned CNT_W       = 4
) (
    input  logic  clk,
    input  logic  reset,
    mdu_if.slave  bus
);

    mdu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0]      pend_hi_q, pend_hi_d;
    logic [31:0]      pend_lo_q, pend_lo_d;
    logic             pend_keep_q, pend_keep_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;

    logic [31:0] res_hi;
    logic [31:0] res_lo;
    logic        div0;
    logic        acc;

    mdu_arith u_arith (
        .op     (bus.op),
        .rs     (bus.rs),
        .rt     (bus.rt),
        .res_hi (res_hi),
        .res_lo (res_lo),
        .div0   (div0)
    );

    assign acc = bus.start && !bus.cancel && (state_q == IDLE) && mdu_is_valid(bus.op);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pend_hi_d   = pend_hi_q;
        pend_lo_d   = pend_lo_q;
        pend_keep_d = pend_keep_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        case (state_q)
            IDLE: begin
                if (acc) begin
                    if (mdu_is_long(bus.op)) begin
                        pend_hi_d   = res_hi;
                        pend_lo_d   = res_lo;
                        pend_keep_d = div0;
                        cnt_d       = (bus.op == MDU_MULT || bus.op == MDU_MULTU)
                                      ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
                        state_d     = RUN;
                    end else if (bus.op == MDU_MTHI) begin
                        hi_d = bus.rs;
                    end else begin
                        lo_d = bus.rs;
                    end
                end
            end
            RUN: begin
                // cnt_q==0 is unreachable but also terminates, so the counter never wraps.
                if (cnt_q <= CNT_W'(1)) begin
                    if (!pend_keep_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            pend_hi_q   <= 32'd0;
            pend_lo_q   <= 32'd0;
            pend_keep_q <= 1'b0;
            hi_q        <= 32'd0;
            lo_q        <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_hi_q   <= pend_hi_d;
            pend_lo_q   <= pend_lo_d;
            pend_keep_q <= pend_keep_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
        end
    end

    assign bus.busy = (state_q == RUN);
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Scoreboard bench for mdu_ctrl: expected {hi,lo} pushed at issue, popped at commit.
module tb_mdu_ctrl;
    import mdu_pkg::*;

    logic clk = 1'b0;
    logic reset;
    mdu_if bus ();

    mdu_ctrl #(
        .MULT_CYCLES (5),
        .DIV_CYCLES  (10),
        .CNT_W       (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    logic [63:0] sb_q[$];
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic pop_check(input string tag);
        if (sb_q.size() == 0) begin
            check({tag, " (scoreboard empty)"}, {bus.hi, bus.lo}, ~{bus.hi, bus.lo});
        end else begin
            check(tag, {bus.hi, bus.lo}, sb_q.pop_front());
        end
    endtask

    // mode 0: plain; mode 1: cancel pulsed during RUN; mode 2: start held during busy
    task automatic run_long(input string tag, input logic [2:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [63:0] exp, input int mode);
        int unsigned lat;
        int unsigned cycles;
        lat = (op == MDU_MULT || op == MDU_MULTU) ? 5 : 10;
        sb_q.push_back(exp);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.rs    = a;
        bus.rt    = b;
        @(posedge clk);
        #1;
        if (mode == 2) begin
            bus.op = MDU_DIV;
            bus.rs = 32'hDEAD_BEEF;
            bus.rt = 32'd3;
        end else begin
            bus.start = 1'b0;
        end
        cycles = 0;
        while (bus.busy && cycles < 50) begin
            if (mode == 1) bus.cancel = (cycles >= 1 && cycles <= 3);
            @(posedge clk);
            #1;
            cycles++;
        end
        bus.start  = 1'b0;
        bus.cancel = 1'b0;
        check({tag, " busy cycles"}, 64'(cycles), 64'(lat));
        pop_check({tag, " result"});
        {m_hi, m_lo} = exp;
        if (mode == 2) begin
            @(posedge clk);
            #1;
            check({tag, " held start ignored"}, 64'(bus.busy), 64'd0);
        end
    endtask

    task automatic run_mt(input string tag, input logic [2:0] op, input logic [31:0] v);
        if (op == MDU_MTHI) m_hi = v;
        else m_lo = v;
        sb_q.push_back({m_hi, m_lo});
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.rs    = v;
        bus.rt    = 32'h5A5A_5A5A;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check({tag, " busy"}, 64'(bus.busy), 64'd0);
        pop_check({tag, " result"});
    endtask

    task automatic run_blocked(input string tag, input logic [2:0] op, input logic cncl);
        @(negedge clk);
        bus.start  = 1'b1;
        bus.op     = op;
        bus.cancel = cncl;
        bus.rs     = 32'h1234_5678;
        bus.rt     = 32'h0000_0009;
        @(posedge clk);
        #1;
        bus.start  = 1'b0;
        bus.cancel = 1'b0;
        check({tag, " busy"}, 64'(bus.busy), 64'd0);
        repeat (11) @(posedge clk);
        #1;
        check({tag, " hi/lo"}, {bus.hi, bus.lo}, {m_hi, m_lo});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int sa;
        int sb;
        longint p;
        logic [31:0] a;
        logic [31:0] b;

        reset      = 1'b1;
        bus.start  = 1'b0;
        bus.op     = 3'd0;
        bus.cancel = 1'b0;
        bus.rs     = 32'd0;
        bus.rt     = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("reset busy", 64'(bus.busy), 64'd0);
        check("reset hi/lo", {bus.hi, bus.lo}, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        run_long("mult", MDU_MULT, 32'hFFFF_FFFE, 32'd3, {32'hFFFF_FFFF, 32'hFFFF_FFFA}, 0);
        run_long("multu", MDU_MULTU, 32'hFFFF_FFFE, 32'd3, {32'h0000_0002, 32'hFFFF_FFFA}, 0);
        run_long("div", MDU_DIV, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 0);
        run_long("divu", MDU_DIVU, 32'd7, 32'd2, {32'd1, 32'd3}, 0);
        run_long("div ovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 0);

        run_mt("mthi", MDU_MTHI, 32'h11);
        run_mt("mtlo", MDU_MTLO, 32'h22);
        run_long("div by 0", MDU_DIV, 32'd100, 32'd0, {32'h11, 32'h22}, 0);
        run_long("divu by 0", MDU_DIVU, 32'd100, 32'd0, {32'h11, 32'h22}, 0);

        run_blocked("cancelled mult", MDU_MULT, 1'b1);
        run_blocked("reserved op", 3'd6, 1'b0);
        run_long("mult cancel in run", MDU_MULT, 32'd1000, 32'd1000, {32'd0, 32'd1000000}, 1);

        run_mt("b2b mtlo", MDU_MTLO, 32'd5);
        run_long("b2b mult", MDU_MULT, 32'd6, 32'd7, {32'd0, 32'd42}, 2);
        run_long("after busy", MDU_MULTU, 32'h8000_0000, 32'd4, {32'd2, 32'd0}, 0);
        run_long("b2b divu", MDU_DIVU, 32'd100, 32'd7, {32'd2, 32'd14}, 0);

        for (int i = 0; i < 3; i++) begin
            a  = $urandom;
            b  = $urandom_range(1, 32'h7FFF_FFFF);
            sa = a;
            sb = b;
            p  = longint'(sa) * longint'(sb);
            run_long("rand mult", MDU_MULT, a, b, p, 0);
            run_long("rand multu", MDU_MULTU, a, b, {32'd0, a} * {32'd0, b}, 0);
            run_long("rand divu", MDU_DIVU, a, b, {a % b, a / b}, 0);
            run_long("rand div", MDU_DIV, a, b, {32'(sa % sb), 32'(sa / sb)}, 0);
        end

        // Async reset in the middle of a divide with nonzero HI/LO already present.
        run_mt("pre-reset mthi", MDU_MTHI, 32'hCAFE_0001);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = MDU_DIV;
        bus.rs    = 32'd50;
        bus.rt    = 32'd5;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("pre-reset busy", 64'(bus.busy), 64'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("mid-run reset busy", 64'(bus.busy), 64'd0);
        check("mid-run reset hi/lo", {bus.hi, bus.lo}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("post-reset busy", 64'(bus.busy), 64'd0);
        check("post-reset hi/lo", {bus.hi, bus.lo}, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
